// File: rtl/run_pkg.sv
// run_sequencer shared types and defaults.
// Imported by the interface, top and timer.
package run_pkg;

  localparam int COUNT_W_DEF = 11;
  localparam int TIMEOUT_DEF = 4095;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    LOAD      = 3'd2,
    START     = 3'd3,
    ARM       = 3'd4,
    WAIT_DONE = 3'd5,
    CAPTURE   = 3'd6,
    FINISH    = 3'd7
  } state_t;

endpackage

// File: rtl/run_sequencer_if.sv
// Link between run_sequencer and the counting FSM.
// master = sequencer side, slave = counting FSM side.
interface run_sequencer_if
  import run_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF
);

  logic               fsm_start;
  logic               fsm_reset;
  logic               load_mem;
  logic               fsm_done;
  logic [COUNT_W-1:0] fsm_count;

  modport master (
    output fsm_start,
    output fsm_reset,
    output load_mem,
    input  fsm_done,
    input  fsm_count
  );

  modport slave (
    input  fsm_start,
    input  fsm_reset,
    input  load_mem,
    output fsm_done,
    output fsm_count
  );

endinterface

// File: rtl/run_sequencer_cycle_timer.sv
// Loadable down-counter shared by the LOAD length
// and the WAIT_DONE timeout.
module cycle_timer
  import run_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/run_sequencer.sv
// Batch sequencer: clears, loads, starts and times
// a counting FSM for N runs, gathering count stats.
module run_sequencer
  import run_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               go,
  input  logic [7:0]         num_runs,
  input  logic [7:0]         load_len,
  run_sequencer_if.master    link,
  output logic               busy,
  output logic               batch_done,
  output logic               timeout_err,
  output logic [7:0]         run_idx,
  output logic [COUNT_W-1:0] last_count,
  output logic [COUNT_W-1:0] min_count,
  output logic [COUNT_W-1:0] max_count,
  output logic [COUNT_W+7:0] total_count
);

  localparam int LW = $clog2(TIMEOUT + 1);
  localparam int TW = (LW > 8) ? LW : 8;
  localparam logic [TW-1:0] TMO_LD = TW'(TIMEOUT - 1);

  state_t             state;
  logic [7:0]         runs_q;
  logic [7:0]         len_q;
  logic               tmr_load;
  logic               tmr_en;
  logic               tmr_zero;
  logic [TW-1:0]      tmr_val;
  logic [COUNT_W-1:0] cnt;
  logic [7:0]         idx_nx;

  assign cnt    = link.fsm_count;
  assign idx_nx = run_idx + 8'd1;

  // Timer holds remaining cycles minus one, so zero marks the last one.
  always_comb begin
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    tmr_val  = TMO_LD;
    unique case (1'b1)
      (state == CLEAR): begin
        tmr_load = (len_q != 8'd0);
        tmr_val  = TW'(len_q - 8'd1);
      end
      (state == ARM): begin
        tmr_load = 1'b1;
      end
      (state == LOAD),
      (state == WAIT_DONE): begin
        tmr_en = 1'b1;
      end
      default: ;
    endcase
  end

  cycle_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tmr_load),
    .en      (tmr_en),
    .val     (tmr_val),
    .zero    (tmr_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      runs_q         <= 8'd0;
      len_q          <= 8'd0;
      link.fsm_start <= 1'b0;
      link.fsm_reset <= 1'b0;
      link.load_mem  <= 1'b0;
      busy           <= 1'b0;
      batch_done     <= 1'b0;
      timeout_err    <= 1'b0;
      run_idx        <= 8'd0;
      last_count     <= '0;
      min_count      <= '1;
      max_count      <= '0;
      total_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            runs_q         <= (num_runs == 8'd0) ? 8'd1 : num_runs;
            len_q          <= load_len;
            run_idx        <= 8'd0;
            total_count    <= '0;
            timeout_err    <= 1'b0;
            min_count      <= '1;
            max_count      <= '0;
            last_count     <= '0;
            busy           <= 1'b1;
            link.fsm_reset <= 1'b1;
            state          <= CLEAR;
          end
        end
        CLEAR: begin
          link.fsm_reset <= 1'b0;
          if (len_q != 8'd0) begin
            link.load_mem <= 1'b1;
            state         <= LOAD;
          end else begin
            link.fsm_start <= 1'b1;
            state          <= START;
          end
        end
        LOAD: begin
          if (tmr_zero) begin
            link.load_mem  <= 1'b0;
            link.fsm_start <= 1'b1;
            state          <= START;
          end
        end
        START: begin
          link.fsm_start <= 1'b0;
          state          <= ARM;
        end
        ARM: begin
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // done wins over a simultaneous terminal count
          if (link.fsm_done) begin
            state <= CAPTURE;
          end else if (tmr_zero) begin
            timeout_err <= 1'b1;
            batch_done  <= 1'b1;
            state       <= FINISH;
          end
        end
        CAPTURE: begin
          last_count  <= cnt;
          total_count <= total_count + {8'd0, cnt};
          run_idx     <= idx_nx;
          if (cnt < min_count) min_count <= cnt;
          if (cnt > max_count) max_count <= cnt;
          if (idx_nx == runs_q) begin
            batch_done <= 1'b1;
            state      <= FINISH;
          end else begin
            link.fsm_reset <= 1'b1;
            state          <= CLEAR;
          end
        end
        FINISH: begin
          batch_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer with a behavioural
// counting FSM (STOP_COUNT=10) on the slave side.
module tb_run_sequencer;
  import run_pkg::*;

  localparam int CW = 11;
  localparam int STOP_COUNT = 10;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          go = 1'b0;
  logic [7:0]    num_runs = 8'd0;
  logic [7:0]    load_len = 8'd0;
  logic          busy;
  logic          batch_done;
  logic          timeout_err;
  logic [7:0]    run_idx;
  logic [CW-1:0] last_count;
  logic [CW-1:0] min_count;
  logic [CW-1:0] max_count;
  logic [CW+7:0] total_count;

  int errors = 0;
  int checks = 0;

  run_sequencer_if #(.COUNT_W(CW)) link ();

  run_sequencer #(.COUNT_W(CW), .TIMEOUT(20)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .go          (go),
    .num_runs    (num_runs),
    .load_len    (load_len),
    .link        (link.master),
    .busy        (busy),
    .batch_done  (batch_done),
    .timeout_err (timeout_err),
    .run_idx     (run_idx),
    .last_count  (last_count),
    .min_count   (min_count),
    .max_count   (max_count),
    .total_count (total_count)
  );

  always #5 clk = ~clk;

  // counting FSM model: done with count STOP_COUNT+1
  logic          m_run = 1'b0;
  logic          m_done = 1'b0;
  logic [CW-1:0] m_cnt = '0;
  logic          stub_low = 1'b0;

  always @(posedge clk) begin
    if (link.fsm_reset) begin
      m_run  <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= '0;
    end else if (link.fsm_start) begin
      m_run  <= 1'b1;
      m_done <= 1'b0;
      m_cnt  <= '0;
    end else if (m_run) begin
      m_cnt <= m_cnt + 1'b1;
      if (m_cnt == CW'(STOP_COUNT)) begin
        m_done <= 1'b1;
        m_run  <= 1'b0;
      end
    end
  end

  assign link.fsm_done  = m_done & ~stub_low;
  assign link.fsm_count = m_cnt;

  int cyc = 0;
  int n_load = 0;
  int n_start = 0;
  int n_reset = 0;
  int n_done = 0;
  int t_start = 0;
  int t_done = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (link.load_mem === 1'b1) n_load = n_load + 1;
    if (link.fsm_reset === 1'b1) n_reset = n_reset + 1;
    if (link.fsm_start === 1'b1) begin
      n_start = n_start + 1;
      t_start = cyc;
    end
    if (batch_done === 1'b1) begin
      n_done = n_done + 1;
      t_done = cyc;
    end
  end

  task automatic do_go(input logic [7:0] nr,
                       input logic [7:0] ll);
    @(negedge clk);
    go = 1'b1;
    num_runs = nr;
    load_len = ll;
    @(negedge clk);
    go = 1'b0;
  endtask

  // returns on the negedge after the FINISH cycle
  task automatic wait_batch(input int budget);
    int k;
    k = 0;
    while (batch_done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (batch_done !== 1'b1) begin
      errors++;
      $display("FAIL wait_batch: batch_done=%b after %0d cycles, want 1",
               batch_done, k);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if ({busy, batch_done, timeout_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000",
               {busy, batch_done, timeout_err});
    end
    checks++;
    if ({link.fsm_start, link.fsm_reset, link.load_mem} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 000",
               {link.fsm_start, link.fsm_reset, link.load_mem});
    end
    checks++;
    if (min_count !== 11'h7FF || max_count !== 11'd0 ||
        last_count !== 11'd0 || total_count !== 19'd0 ||
        run_idx !== 8'd0) begin
      errors++;
      $display("FAIL reset_stats: min=%h max=%h last=%h tot=%h idx=%h",
               min_count, max_count, last_count, total_count, run_idx);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int l0, s0, r0, d0;
    l0 = n_load; s0 = n_start; r0 = n_reset; d0 = n_done;
    do_go(8'd1, 8'd3);
    wait_batch(200);
    checks++;
    if (n_load - l0 !== 3) begin
      errors++;
      $display("FAIL single_load: got %0d cycles want 3", n_load - l0);
    end
    checks++;
    if (n_start - s0 !== 1 || n_reset - r0 !== 1) begin
      errors++;
      $display("FAIL single_pulses: start=%0d reset=%0d want 1 1",
               n_start - s0, n_reset - r0);
    end
    checks++;
    if (n_done - d0 !== 1) begin
      errors++;
      $display("FAIL single_done: got %0d want 1", n_done - d0);
    end
    checks++;
    if (last_count !== 11'd11 || min_count !== 11'd11 ||
        max_count !== 11'd11 || total_count !== 19'd11) begin
      errors++;
      $display("FAIL single_stats: last=%0d min=%0d max=%0d tot=%0d want 11",
               last_count, min_count, max_count, total_count);
    end
    checks++;
    if (run_idx !== 8'd1 || timeout_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_end: idx=%0d terr=%b busy=%b want 1 0 0",
               run_idx, timeout_err, busy);
    end
  endtask

  task automatic test_batch();
    int l0, s0, r0;
    l0 = n_load; s0 = n_start; r0 = n_reset;
    do_go(8'd4, 8'd0);
    wait_batch(400);
    checks++;
    if (n_load - l0 !== 0) begin
      errors++;
      $display("FAIL batch_load: got %0d want 0", n_load - l0);
    end
    checks++;
    if (n_start - s0 !== 4 || n_reset - r0 !== 4) begin
      errors++;
      $display("FAIL batch_pulses: start=%0d reset=%0d want 4 4",
               n_start - s0, n_reset - r0);
    end
    checks++;
    if (total_count !== 19'd44 || run_idx !== 8'd4) begin
      errors++;
      $display("FAIL batch_total: tot=%0d idx=%0d want 44 4",
               total_count, run_idx);
    end
    checks++;
    if (timeout_err !== 1'b0 || min_count !== 11'd11 ||
        max_count !== 11'd11) begin
      errors++;
      $display("FAIL batch_misc: terr=%b min=%0d max=%0d want 0 11 11",
               timeout_err, min_count, max_count);
    end
  endtask

  task automatic test_timeout();
    stub_low = 1'b1;
    do_go(8'd1, 8'd0);
    wait_batch(200);
    stub_low = 1'b0;
    checks++;
    if (timeout_err !== 1'b1 || run_idx !== 8'd0) begin
      errors++;
      $display("FAIL timeout_flag: terr=%b idx=%0d want 1 0",
               timeout_err, run_idx);
    end
    // START, ARM, 20 WAIT_DONE cycles, then FINISH
    checks++;
    if (t_done - t_start !== 22) begin
      errors++;
      $display("FAIL timeout_len: got %0d want 22", t_done - t_start);
    end
    checks++;
    if (total_count !== 19'd0 || min_count !== 11'h7FF) begin
      errors++;
      $display("FAIL timeout_stats: tot=%0d min=%h want 0 7ff",
               total_count, min_count);
    end
  endtask

  task automatic test_busy_go();
    int s0, l0;
    s0 = n_start; l0 = n_load;
    do_go(8'd2, 8'd2);
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL busy_mid: busy=%b terr=%b want 1 0", busy, timeout_err);
    end
    go = 1'b1;
    num_runs = 8'd5;
    load_len = 8'd7;
    @(negedge clk);
    go = 1'b0;
    wait_batch(400);
    checks++;
    if (run_idx !== 8'd2 || total_count !== 19'd22) begin
      errors++;
      $display("FAIL busy_stats: idx=%0d tot=%0d want 2 22",
               run_idx, total_count);
    end
    checks++;
    if (n_start - s0 !== 2 || n_load - l0 !== 4) begin
      errors++;
      $display("FAIL busy_pulses: start=%0d load=%0d want 2 4",
               n_start - s0, n_load - l0);
    end
  endtask

  task automatic test_reset_mid();
    int k, d0, l0;
    do_go(8'd3, 8'd0);
    k = 0;
    while (link.fsm_start !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_busy: got %b want 1", busy);
    end
    d0 = n_done;
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || run_idx !== 8'd0 || min_count !== 11'h7FF ||
        {link.fsm_start, link.fsm_reset, link.load_mem} !== 3'b000) begin
      errors++;
      $display("FAIL rmid_async: busy=%b idx=%0d min=%h strobes=%b",
               busy, run_idx, min_count,
               {link.fsm_start, link.fsm_reset, link.load_mem});
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (n_done !== d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_nodone: done=%0d busy=%b want %0d 0",
               n_done, busy, d0);
    end
    l0 = n_load;
    do_go(8'd1, 8'd2);
    wait_batch(200);
    checks++;
    if (run_idx !== 8'd1 || total_count !== 19'd11 || n_load - l0 !== 2) begin
      errors++;
      $display("FAIL rmid_next: idx=%0d tot=%0d load=%0d want 1 11 2",
               run_idx, total_count, n_load - l0);
    end
  endtask

  task automatic test_zero_runs();
    int s0;
    s0 = n_start;
    do_go(8'd0, 8'd0);
    wait_batch(200);
    checks++;
    if (n_start - s0 !== 1 || run_idx !== 8'd1 || total_count !== 19'd11) begin
      errors++;
      $display("FAIL zero_runs: start=%0d idx=%0d tot=%0d want 1 1 11",
               n_start - s0, run_idx, total_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_batch();
    test_timeout();
    test_busy_go();
    test_reset_mid();
    test_zero_runs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 Parameter COUNT_W, default 11: width of the run-cycle count returned by the counting FSM.
REQ-002 Parameter TIMEOUT, default 4095: maximum number of WAIT_DONE cycles before a run is aborted.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 go  input  1  one-cycle request to start a batch; sampled only in IDLE.
REQ-006 num_runs  input  8  runs per batch, latched on go; 0 is treated as 1.
REQ-007 load_len  input  8  load_mem cycles per run, latched on go; 0 skips LOAD.
REQ-008 fsm_done  input  1  done output of the counting FSM.
REQ-009 fsm_count  input  COUNT_W  clock_count output of the counting FSM.
REQ-010 fsm_start  output  1  start pulse to the counting FSM.
REQ-011 fsm_reset  output  1  synchronous reset to the counting FSM.
REQ-012 load_mem  output  1  memory-load strobe to the counting FSM.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 batch_done  output  1  one-cycle pulse at batch end, with or without error.
REQ-015 timeout_err  output  1  sticky flag: a run exceeded TIMEOUT; cleared on the next accepted go.
REQ-016 run_idx  output  8  number of runs completed in the current batch.
REQ-017 last_count, min_count, max_count  output  COUNT_W each  statistics of the captured fsm_count values.
REQ-018 total_count  output  COUNT_W+8  sum of the captured counts.

Function
REQ-019 The FSM SHALL have these states:
- IDLE, CLEAR, LOAD, START, ARM, WAIT_DONE, CAPTURE, FINISH.
REQ-020 IDLE SHALL behave as follows:
- go=1 latches num_runs and load_len.
- run_idx, total_count and timeout_err are zeroed; min_count is set to all-ones; max_count and last_count are set to 0.
- Next state is CLEAR.
- go while busy is ignored.
REQ-021 CLEAR SHALL assert fsm_reset for exactly 1 cycle, then go to LOAD (or to START if load_len=0).
REQ-022 LOAD SHALL assert load_mem for exactly load_len consecutive cycles, then go to START.
REQ-023 START SHALL assert fsm_start for exactly 1 cycle, then go to ARM.
REQ-024 ARM SHALL last 1 cycle with fsm_done ignored (stale done from the prior run), then go to WAIT_DONE.
REQ-025 WAIT_DONE SHALL run a timeout counter:
- The counter increments every cycle.
- fsm_done=1 leads to CAPTURE.
- The counter reaching TIMEOUT with done still low sets timeout_err and leads to FINISH.
REQ-026 CAPTURE SHALL register fsm_count, in one cycle, into:
- last_count;
- min_count (if smaller) and max_count (if larger);
- total_count, by adding it zero-extended.
REQ-027 CAPTURE SHALL also increment run_idx; it then goes to FINISH if run_idx+1 equals the effective num_runs, else to CLEAR.
REQ-028 FINISH SHALL pulse batch_done for 1 cycle, then go to IDLE; the statistics outputs hold until the next go.
REQ-029 fsm_start, fsm_reset and load_mem SHALL be registered outputs, mutually exclusive and never asserted in IDLE or FINISH.
REQ-030 total_count SHALL NOT overflow: 255 runs × (2^COUNT_W−1) fits in COUNT_W+8 bits.
REQ-031 fsm_done=1 and the timeout terminal count in the same cycle SHALL resolve as a capture, with no error.

Reset
REQ-032 reset_n low SHALL asynchronously force:
- state IDLE;
- all outputs 0, except min_count all-ones;
- internal counters 0.
REQ-033 Reset mid-batch SHALL abandon the batch without a batch_done pulse; the counting FSM is reset at the next batch's CLEAR.

Structure
REQ-034 State encodings, COUNT_W and TIMEOUT defaults SHALL reside in the shared package run_pkg.
REQ-035 The timeout/load-length down-counter SHALL be the sub-module cycle_timer (load, enable, zero flag); all else is inline.

Verification
REQ-036 The bench SHALL cover these directed scenarios, connected to the real counting FSM (STOP_COUNT=10):
- Single run, go with num_runs=1, load_len=3 -> load_mem high 3 cycles, one fsm_start pulse, last_count=min=max=total=11, batch_done once, run_idx=1.
- Batch, num_runs=4, load_len=0 -> no load_mem, four fsm_reset and four fsm_start pulses, total_count=44, timeout_err=0.
- Timeout, fsm_done stubbed low, TIMEOUT=20 -> timeout_err=1 after 20 WAIT_DONE cycles, batch_done pulses, run_idx=0.
- go asserted while busy -> ignored, batch statistics unchanged.
- reset_n dropped during WAIT_DONE -> immediate IDLE, outputs reset values, no batch_done; the next go completes normally.
- num_runs=0 -> exactly one run executed.
